alu_mul_sequencer: RTL and testbench

- Multi-cycle unsigned shift-and-add multiplier controller.
- Has no adder of its own. It drives the operand and opcode inputs of the external shared 64-bit ALU and captures the ALU result.
- Sits beside the ALU in the execute stage. The parent muxes ALU inputs to this block while `busy_out` is high.
- Produces the low XLEN bits of the product and uses valid/ready handshakes on both the request and response sides.

---
 rtl/alu_pkg.sv | 9 +
 rtl/alu_mul_sequencer.sv | 71 +++++++
 tb/tb_alu_mul_sequencer.sv | 130 +++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// alu_pkg: shared ALU opcodes, default datapath width and multiplier sequencer states.
package alu_pkg;
  localparam logic [2:0] ALU_OP_SUB = 3'b000;
  localparam logic [2:0] ALU_OP_AND = 3'b001;
  localparam logic [2:0] ALU_OP_OR  = 3'b011;
  localparam logic [2:0] ALU_OP_ADD = 3'b111;
  localparam int XLEN_DEFAULT = 64;
  typedef enum logic [1:0] {IDLE, RUN, DONE} mulState_t;
endpackage

// File: rtl/alu_mul_sequencer.sv
// alu_mul_sequencer: shift-and-add multiplier borrowing the shared external ALU for its additions.
// Define ALU_MUL_EARLY_TERM_EN to finish as soon as the remaining multiplier bits are all zero.
module alu_mul_sequencer
  import alu_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT
) (
  input  logic            clk_in,
  input  logic            resetN_in,
  input  logic            reqValid_in,
  output logic            reqReady_out,
  input  logic [XLEN-1:0] multiplicand_in,
  input  logic [XLEN-1:0] multiplier_in,
  output logic            respValid_out,
  input  logic            respReady_in,
  output logic [XLEN-1:0] product_out,
  output logic            busy_out,
  output logic [XLEN-1:0] aluOperand1_out,
  output logic [XLEN-1:0] aluOperand2_out,
  output logic [2:0]      aluOpcode_out,
  input  logic [XLEN-1:0] aluResult_in
);
  localparam int CNT_W = $clog2(XLEN);
  mulState_t r_state, w_next;
  logic [XLEN-1:0] r_acc, r_mcand, r_mplier;
  logic [CNT_W-1:0] r_count;
  logic w_last, w_accept;
  assign w_accept = r_state == IDLE && reqValid_in;
`ifdef ALU_MUL_EARLY_TERM_EN
  assign w_last = r_count == CNT_W'(XLEN-1) || (r_mplier >> 1) == '0;
`else
  assign w_last = r_count == CNT_W'(XLEN-1);
`endif
  always_ff @(posedge clk_in or negedge resetN_in)
    if (!resetN_in) r_state <= IDLE;
    else r_state <= w_next;
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = reqValid_in ? RUN : IDLE;
      RUN:     w_next = w_last ? DONE : RUN;
      DONE:    w_next = respReady_in ? IDLE : DONE;
      default: w_next = IDLE;
    endcase
  end
  // The ALU computes acc + mcand every RUN cycle; it is only kept when the current multiplier bit is set.
  always_ff @(posedge clk_in or negedge resetN_in)
    if (!resetN_in) begin
      r_acc    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_count  <= '0;
    end else if (w_accept) begin
      r_acc    <= '0;
      r_mcand  <= multiplicand_in;
      r_mplier <= multiplier_in;
      r_count  <= '0;
    end else if (r_state == RUN) begin
      if (r_mplier[0]) r_acc <= aluResult_in;
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
      r_count  <= r_count + 1'b1;
    end
  assign reqReady_out    = r_state == IDLE;
  assign busy_out        = r_state == RUN;
  assign respValid_out   = r_state == DONE;
  assign product_out     = r_state == DONE ? r_acc : '0;
  assign aluOperand1_out = r_state == RUN ? r_acc : '0;
  assign aluOperand2_out = r_state == RUN ? r_mcand : '0;
  assign aluOpcode_out   = ALU_OP_ADD;
endmodule

// File: tb/tb_alu_mul_sequencer.sv
// tb_alu_mul_sequencer: directed table, corner sequences and random operands against a plain-arithmetic product/latency model.
module tb_alu_mul_sequencer;
  logic clk = 0, rst_n = 0;
  logic req_valid = 0, req_ready, resp_valid, resp_ready = 0, busy;
  logic [63:0] mcand = 0, mplier = 0, product, op1, op2, alu_res;
  logic [2:0] opcode;
  int checks = 0, failures = 0;

  always #5 clk = ~clk;

  // stand-in for the parent's shared ALU, zero latency
  always_comb begin
    alu_res = '0;
    case (opcode)
      3'b111: alu_res = op1 + op2;
      3'b000: alu_res = op1 - op2;
      3'b001: alu_res = op1 & op2;
      3'b011: alu_res = op1 | op2;
      default: alu_res = '0;
    endcase
  end

  alu_mul_sequencer dut (
    .clk_in(clk), .resetN_in(rst_n), .reqValid_in(req_valid), .reqReady_out(req_ready),
    .multiplicand_in(mcand), .multiplier_in(mplier), .respValid_out(resp_valid),
    .respReady_in(resp_ready), .product_out(product), .busy_out(busy),
    .aluOperand1_out(op1), .aluOperand2_out(op2), .aluOpcode_out(opcode), .aluResult_in(alu_res)
  );

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic int exp_run(input logic [63:0] b);
    int n;
`ifdef ALU_MUL_EARLY_TERM_EN
    n = 1;
    for (int i = 0; i < 64; i++) if (b[i]) n = i + 1;
`else
    n = 64;
`endif
    return n;
  endfunction

  task automatic check_reset_outputs(input string nm);
    check({nm, "_req_ready"}, {63'd0, req_ready}, 64'd1);
    check({nm, "_resp_valid"}, {63'd0, resp_valid}, 64'd0);
    check({nm, "_busy"}, {63'd0, busy}, 64'd0);
    check({nm, "_product"}, product, 64'd0);
    check({nm, "_op1"}, op1, 64'd0);
    check({nm, "_op2"}, op2, 64'd0);
    check({nm, "_opcode"}, {61'd0, opcode}, 64'd7);
  endtask

  task automatic do_op(input logic [63:0] a, input logic [63:0] b, input logic [63:0] exp_p,
                       input int bp, input bit pulse, input string nm);
    int guard = 0, nbusy = 0;
    bit opc_ok = 1;
    @(negedge clk);
    while (!req_ready && guard < 200) begin @(negedge clk); guard++; end
    mcand = a; mplier = b; req_valid = 1;
    @(posedge clk); #1;
    req_valid = 0; mcand = {$urandom, $urandom}; mplier = {$urandom, $urandom};
    guard = 0;
    while (!resp_valid && guard < 300) begin
      if (busy) nbusy++;
      if (opcode !== 3'b111) opc_ok = 0;
      req_valid = pulse && nbusy == 3;
      @(posedge clk); #1;
      guard++;
    end
    req_valid = 0;
    check({nm, "_timeout"}, {63'd0, guard >= 300}, 64'd0);
    check({nm, "_run_cycles"}, 64'(nbusy), 64'(exp_run(b)));
    check({nm, "_opcode_add"}, {63'd0, opc_ok}, 64'd1);
    check({nm, "_product"}, product, exp_p);
    for (int i = 0; i < bp; i++) begin
      @(posedge clk); #1;
      check({nm, "_hold_valid"}, {63'd0, resp_valid}, 64'd1);
      check({nm, "_hold_product"}, product, exp_p);
      check({nm, "_hold_not_ready"}, {63'd0, req_ready}, 64'd0);
    end
    resp_ready = 1;
    check({nm, "_ready_low_in_done"}, {63'd0, req_ready}, 64'd0);
    @(posedge clk); #1;
    resp_ready = 0;
    check({nm, "_idle_ready"}, {63'd0, req_ready}, 64'd1);
    check({nm, "_idle_valid"}, {63'd0, resp_valid}, 64'd0);
  endtask

  typedef struct {
    logic [63:0] a, b, p;
    int bp;
    string nm;
  } vec_t;
  vec_t vecs[4];

  initial begin
    logic [63:0] ra, rb;
    vecs[0] = '{64'd3, 64'd5, 64'd15, 0, "a3_b5"};
    vecs[1] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 0, "all_ones"};
    vecs[2] = '{64'h1234, 64'd0, 64'd0, 0, "b_zero"};
    vecs[3] = '{64'd7, 64'd6, 64'd42, 10, "backpressure"};
    #3 check_reset_outputs("reset");
    @(negedge clk); rst_n = 1;
    for (int i = 0; i < 4; i++) do_op(vecs[i].a, vecs[i].b, vecs[i].p, vecs[i].bp, 0, vecs[i].nm);
    do_op(64'd7, 64'hFF00, 64'd7 * 64'hFF00, 0, 1, "ignored_req");
    do_op(64'd11, 64'd13, 64'd143, 0, 0, "after_ignored");
    @(negedge clk);
    mcand = 9; mplier = 9; req_valid = 1;
    @(posedge clk); #1 req_valid = 0;
    repeat (3) @(posedge clk);
    #2 rst_n = 0;
    #1 check_reset_outputs("async_reset");
    @(negedge clk); rst_n = 1;
    #1 check("post_reset_no_resp", {63'd0, resp_valid}, 64'd0);
    do_op(64'd2, 64'd3, 64'd6, 0, 0, "after_reset");
    for (int i = 0; i < 20; i++) begin
      ra = {$urandom, $urandom};
      rb = {$urandom, $urandom} >> $urandom_range(0, 63);
      do_op(ra, rb, ra * rb, $urandom_range(0, 3), 0, "random");
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
